// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - command-driven sequencer for the prescaled 4-bit up-counter datapath
module count_seq_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_CLR,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_RUN    = 2'b00;
    localparam logic [1:0] OP_PAUSE  = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

    state_t           state, state_nx;
    logic [7:0]       presc, presc_nx;
    logic [WIDTH-1:0] target, target_nx;
    logic             en_nx;
    logic             err_nx;
    logic             accept;
    logic             tick;

    assign accept = cmd_valid && cmd_ready;
    assign tick   = (presc == PS_LAST);

    // Next-state and next-output decode; an accepted PAUSE/CLEAR outranks a same-cycle tick
    always_comb begin
        state_nx  = state;
        presc_nx  = presc;
        target_nx = target;
        en_nx     = 1'b0;
        err_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                presc_nx = 8'd0;
                if (accept) begin
                    case (cmd_op)
                        OP_RUN: begin
                            target_nx = cmd_target;
                            state_nx  = S_RUN;
                        end
                        OP_CLEAR: state_nx = S_CLR;
                        default:  err_nx   = 1'b1;
                    endcase
                end
            end
            S_RUN: begin
                // The prescaler keeps its phase running through the cycle a PAUSE lands in
                presc_nx = tick ? 8'd0 : 8'(presc + 8'd1);
                if (accept && cmd_op == OP_PAUSE) begin
                    state_nx = S_PAUSED;
                end else if (accept && cmd_op == OP_CLEAR) begin
                    state_nx = S_CLR;
                end else begin
                    err_nx = accept;
                    if (tick) begin
                        if (cnt_value == target) begin
                            state_nx = S_DONE;
                        end else begin
                            en_nx = 1'b1;
                        end
                    end
                end
            end
            S_PAUSED: begin
                if (accept) begin
                    case (cmd_op)
                        OP_RESUME: state_nx = S_RUN;
                        OP_CLEAR:  state_nx = S_CLR;
                        default:   err_nx   = 1'b1;
                    endcase
                end
            end
            S_CLR: begin
                presc_nx = 8'd0;
                state_nx = S_IDLE;
            end
            S_DONE: begin
                presc_nx = 8'd0;
                state_nx = S_IDLE;
            end
            default: begin
                presc_nx = 8'd0;
                state_nx = S_IDLE;
            end
        endcase
    end

    // State, prescaler, target and every output are registered off the decoded next values
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            presc     <= 8'd0;
            target    <= '0;
            cnt_en    <= 1'b0;
            cnt_clr   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_nx;
            presc     <= presc_nx;
            target    <= target_nx;
            cnt_en    <= en_nx;
            cnt_clr   <= (state_nx == S_CLR);
            done      <= (state_nx == S_DONE);
            busy      <= (state_nx == S_RUN) || (state_nx == S_PAUSED);
            err       <= err_nx;
            cmd_ready <= (state_nx == S_IDLE) || (state_nx == S_RUN) || (state_nx == S_PAUSED);
        end
    end

endmodule
